keypad_scanner: RTL and testbench

//  Parametrised matrix-keypad scanner; successor to the fixed 4x4 keypad driver.

---
 rtl/keypad_pkg.sv | 10 +
 rtl/keypad_if.sv | 13 +
 rtl/keypad_col_scan.sv | 48 ++++
 rtl/keypad_scanner.sv | 84 ++++++++
 tb/tb_keypad_scanner.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type, no-key code and 4x4 legend for the keypad scanner
package keypad_pkg;
    typedef enum logic [1:0] {IDLE, DEB, HELD, REL} state_e;
    localparam int KEY_NONE = 16;
    localparam logic [0:15][7:0] LEGEND = {"1", "2", "3", "A", "4", "5", "6", "B",
                                           "7", "8", "9", "C", "F", "0", "E", "D"};
    function automatic logic [7:0] key_legend(input logic [4:0] code);
        return code[4] ? " " : LEGEND[code[3:0]];
    endfunction
endpackage

// File: rtl/keypad_if.sv
// keypad_if: keypad pins plus event outputs; slave is the scanner, master the consuming side
interface keypad_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int KEY_W = $clog2(ROWS * COLS + 1)
);
    logic [ROWS-1:0] fila;
    logic [COLS-1:0] col;
    logic [KEY_W-1:0] key_code;
    logic key_valid, key_press, key_repeat, key_release, multi_key;
    modport master (output fila, input col, key_code, key_valid, key_press, key_repeat, key_release, multi_key);
    modport slave (input fila, output col, key_code, key_valid, key_press, key_repeat, key_release, multi_key);
endinterface

// File: rtl/keypad_col_scan.sv
// keypad_col_scan: column ring with dwell counter, row synchroniser and per-frame snapshot
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS-1:0]      fila,
    output logic [COLS-1:0]      col,
    output logic [ROWS*COLS-1:0] frame,
    output logic                 frame_end
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(COLS);
    logic [DW-1:0] div;
    logic [CW-1:0] cidx;
    logic [ROWS-1:0] s1, s2;
    logic [ROWS-1:0] snap [COLS];
    logic last;
    assign last = div == DW'(SCAN_DIV - 1);
    assign frame_end = last && cidx == CW'(COLS - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            div <= '0;
            cidx <= '0;
            col <= COLS'(1);
            s1 <= '0;
            s2 <= '0;
            for (int i = 0; i < COLS; i++) snap[i] <= '0;
        end else begin
            s1 <= fila;
            s2 <= s1;
            div <= last ? '0 : div + DW'(1);
            if (last) begin
                snap[cidx] <= s2;
                cidx <= (cidx == CW'(COLS - 1)) ? '0 : cidx + CW'(1);
                col <= {col[COLS-2:0], col[COLS-1]};
            end
        end
    // The last column is taken live so the frame is complete on the frame-end cycle
    always_comb
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                frame[r*COLS+c] = (c == COLS - 1) ? s2[r] : snap[c][r];
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner with frame debounce, ghost rejection and auto-repeat
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3,
    parameter int REPEAT_EN = 0,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE = 4,
    parameter int KEY_W = $clog2(ROWS * COLS + 1)
) (
    input logic   clk,
    input logic   rst_n,
    keypad_if.slave bus
);
    localparam int NK = ROWS * COLS;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [KEY_W-1:0] NONE = KEY_W'(NK);
    localparam logic [1:0] S_IDLE = IDLE, S_DEB = DEB, S_HELD = HELD, S_REL = REL;
    logic [NK-1:0] frame;
    logic frame_end, acc, rel, rpt, deb_done;
    logic [1:0] state, nxt, n;
    logic [KEY_W-1:0] idx, cand;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] rep, rep_n;
    keypad_col_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV)) u_scan (
        .clk(clk), .rst_n(rst_n), .fila(bus.fila), .col(bus.col), .frame(frame), .frame_end(frame_end)
    );
    always_comb begin
        n = 2'd0;
        idx = '0;
        for (int i = 0; i < NK; i++)
            if (frame[i]) begin
                n = (n == 2'd0) ? 2'd1 : 2'd2;
                idx = KEY_W'(i);
            end
        cnt_n = (cnt == CW'(DEBOUNCE)) ? cnt : cnt + CW'(1);
        deb_done = cnt_n == CW'(DEBOUNCE);
        rep_n = rep + RW'(1);
        rpt = frame_end && state == S_HELD && n != 2'd0 && REPEAT_EN != 0 &&
              (rep_n == RW'(REPEAT_DELAY) || rep_n == RW'(REPEAT_DELAY + REPEAT_RATE));
        acc = frame_end && n == 2'd1 && ((state == S_IDLE && DEBOUNCE <= 1) || (state == S_DEB && idx == cand && deb_done));
        rel = frame_end && n == 2'd0 && ((state == S_HELD && DEBOUNCE <= 1) || (state == S_REL && deb_done));
        case (state)
            S_IDLE:  nxt = (n != 2'd1) ? S_IDLE : (DEBOUNCE <= 1) ? S_HELD : S_DEB;
            S_DEB:   nxt = (n != 2'd1 || idx != cand) ? S_IDLE : deb_done ? S_HELD : S_DEB;
            S_HELD:  nxt = (n != 2'd0) ? S_HELD : (DEBOUNCE <= 1) ? S_IDLE : S_REL;
            default: nxt = (n != 2'd0) ? S_HELD : deb_done ? S_IDLE : S_REL;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_IDLE;
            cand <= '0;
            cnt <= '0;
            rep <= '0;
            bus.key_code <= NONE;
            bus.key_valid <= 1'b0;
            bus.key_press <= 1'b0;
            bus.key_repeat <= 1'b0;
            bus.key_release <= 1'b0;
            bus.multi_key <= 1'b0;
        end else begin
            bus.key_press <= acc || rpt;
            bus.key_repeat <= rpt;
            bus.key_release <= rel;
            bus.multi_key <= frame_end && state == S_IDLE && n == 2'd2;
            if (acc || rel) begin
                bus.key_code <= acc ? idx : NONE;
                bus.key_valid <= acc;
            end
            // Repeat counter reloads to the first-repeat point so it never wraps
            if (frame_end) begin
                state <= nxt;
                cnt <= (state == S_DEB || state == S_REL) ? cnt_n : CW'(1);
                cand <= (state == S_IDLE) ? idx : cand;
                rep <= acc ? '0 : (state == S_HELD && n != 2'd0) ?
                       ((rep_n == RW'(REPEAT_DELAY + REPEAT_RATE)) ? RW'(REPEAT_DELAY) : rep_n) : rep;
            end
        end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: two scanners (no repeat / repeat) on one simulated 4x4 keypad, checked every cycle
module tb_keypad_scanner;
    localparam int DEBN = 3, DLY = 8, RATE = 4;
    typedef struct {
        logic [15:0] mask;
        int frames, press, rel, multi, code;
        bit valid;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [15:0] mask = '0;
    int cyc = 0, n_chk = 0, n_fail = 0, sp, sr, sm, p_frame;
    int rq[$];
    int held[2], streak[2], cand[2], zeros[2], hf[2], code[2];
    bit valid[2], e_press[2], e_rpt[2], e_rel[2], e_multi[2];
    vec_t tbl[12];
    keypad_if #(.ROWS(4), .COLS(4)) ia ();
    keypad_if #(.ROWS(4), .COLS(4)) ib ();
    function automatic logic [3:0] rows_of(input logic [15:0] m, input logic [3:0] c);
        logic [3:0] f = '0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (m[r*4+k] && c[k]) f[r] = 1'b1;
        return f;
    endfunction
    assign ia.fila = rows_of(mask, ia.col);
    assign ib.fila = rows_of(mask, ib.col);
    keypad_scanner #(.REPEAT_EN(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    keypad_scanner #(.REPEAT_EN(1), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    always #5 clk = ~clk;
    function automatic logic [13:0] pk_a();
        return {ia.col, ia.key_code, ia.key_valid, ia.key_press, ia.key_repeat, ia.key_release, ia.multi_key};
    endfunction
    function automatic logic [13:0] pk_b();
        return {ib.col, ib.key_code, ib.key_valid, ib.key_press, ib.key_repeat, ib.key_release, ib.multi_key};
    endfunction
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            held[d] = 0; streak[d] = 0; cand[d] = 0; zeros[d] = 0; hf[d] = 0; code[d] = 16; valid[d] = 0;
        end
    endtask
    // Frame-level behaviour: streak of identical single keys to accept, streak of empty frames to release
    task automatic model_frame(input int d, input int n, input int idx);
        if (held[d] == 0) begin
            if (streak[d] > 0 && (n != 1 || idx != cand[d])) streak[d] = 0;
            else if (n == 1) begin
                if (streak[d] == 0) cand[d] = idx;
                streak[d]++;
            end else if (n > 1) e_multi[d] = 1;
            if (streak[d] == DEBN) begin
                held[d] = 1; code[d] = cand[d]; valid[d] = 1; e_press[d] = 1; hf[d] = 0; zeros[d] = 0; streak[d] = 0;
            end
        end else if (n == 0) begin
            zeros[d]++;
            if (zeros[d] == DEBN) begin
                held[d] = 0; code[d] = 16; valid[d] = 0; e_rel[d] = 1;
            end
        end else begin
            if (zeros[d] == 0) begin
                hf[d]++;
                if (d == 1 && hf[d] >= DLY && (hf[d] - DLY) % RATE == 0) begin
                    e_press[d] = 1; e_rpt[d] = 1;
                end
            end
            zeros[d] = 0;
        end
    endtask
    task automatic step();
        int idx;
        logic [3:0] ec;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            e_press[d] = 0; e_rpt[d] = 0; e_rel[d] = 0; e_multi[d] = 0;
        end
        if (cyc % 16 == 0) begin
            idx = 0;
            for (int i = 0; i < 16; i++) if (mask[i]) idx = i;
            model_frame(0, $countones(mask), idx);
            model_frame(1, $countones(mask), idx);
        end
        @(negedge clk);
        ec = 4'b0001 << ((cyc / 4) % 4);
        chk($sformatf("cyc%0d dut_a", cyc), pk_a(), {ec, 5'(code[0]), valid[0], e_press[0], e_rpt[0], e_rel[0], e_multi[0]});
        chk($sformatf("cyc%0d dut_b", cyc), pk_b(), {ec, 5'(code[1]), valid[1], e_press[1], e_rpt[1], e_rel[1], e_multi[1]});
        sp += int'(ia.key_press); sr += int'(ia.key_release); sm += int'(ia.multi_key);
        if (ib.key_repeat) rq.push_back(cyc / 16);
        if (ib.key_press && !ib.key_repeat) p_frame = cyc / 16;
    endtask
    task automatic run_frames(input logic [15:0] m, input int k);
        mask = m;
        repeat (16 * k) step();
    endtask
    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        logic [15:0] m;
        int a, b;
        tbl[0] = '{16'h0000, 2, 0, 0, 0, 16, 0};
        tbl[1] = '{16'h0040, 5, 1, 0, 0, 6, 1};
        tbl[2] = '{16'h0000, 3, 0, 1, 0, 16, 0};
        tbl[3] = '{16'h0040, 2, 0, 0, 0, 16, 0};
        tbl[4] = '{16'h0000, 1, 0, 0, 0, 16, 0};
        tbl[5] = '{16'h0021, 3, 0, 0, 3, 16, 0};
        tbl[6] = '{16'h0000, 1, 0, 0, 0, 16, 0};
        tbl[7] = '{16'h0008, 3, 1, 0, 0, 3, 1};
        tbl[8] = '{16'h1008, 2, 0, 0, 0, 3, 1};
        tbl[9] = '{16'h0000, 2, 0, 0, 0, 3, 1};
        tbl[10] = '{16'h0008, 1, 0, 0, 0, 3, 1};
        tbl[11] = '{16'h0000, 3, 0, 1, 0, 16, 0};
        model_reset();
        repeat (2) begin
            @(negedge clk);
            chk("reset dut_a", pk_a(), {4'b0001, 5'd16, 5'b0});
            chk("reset dut_b", pk_b(), {4'b0001, 5'd16, 5'b0});
        end
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            sp = 0; sr = 0; sm = 0;
            run_frames(tbl[i].mask, tbl[i].frames);
            chk($sformatf("tbl%0d", i), {8'(sp), 8'(sr), 8'(sm), 5'(ia.key_code), ia.key_valid},
                {8'(tbl[i].press), 8'(tbl[i].rel), 8'(tbl[i].multi), 5'(tbl[i].code), tbl[i].valid});
        end
        rq.delete();
        p_frame = -100;
        run_frames(16'h8000, 20);
        chk("repeat count", rq.size(), 3);
        for (int i = 0; i < rq.size() && i < 3; i++)
            chk($sformatf("repeat%0d offset", i), rq[i] - p_frame, DLY + i * RATE);
        run_frames(16'h0000, 3);
        run_frames(16'h0008, 4);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("async reset dut_a", pk_a(), {4'b0001, 5'd16, 5'b0});
        chk("async reset dut_b", pk_b(), {4'b0001, 5'd16, 5'b0});
        repeat (3) begin
            @(negedge clk);
            chk("reset hold dut_a", pk_a(), {4'b0001, 5'd16, 5'b0});
            chk("reset hold dut_b", pk_b(), {4'b0001, 5'd16, 5'b0});
        end
        mask = '0;
        rst_n = 1'b1;
        cyc = 0;
        model_reset();
        run_frames(16'h0000, 2);
        m = '0;
        for (int f = 0; f < 50; f++) begin
            case ($urandom_range(0, 3))
                0: m = m;
                1: m = '0;
                2: m = 16'(1) << $urandom_range(0, 15);
                default: begin
                    a = $urandom_range(0, 15);
                    b = (a + $urandom_range(1, 15)) % 16;
                    m = (16'(1) << a) | (16'(1) << b);
                end
            endcase
            run_frames(m, $urandom_range(1, 10));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
